// File: rtl/multdiv_ctrl_pkg.sv
// Shared definitions for the multdiv sequencing controller.
// Holds the FSM state encoding, datapath widths, the rstatus defaults and
// the payload captured from execute when an operation is accepted.
package multdiv_ctrl_pkg;

    localparam int unsigned DATA_W           = 32;
    localparam int unsigned REG_W            = 5;
    localparam int unsigned WD_W             = 6;
    localparam int unsigned TIMEOUT_DEF      = 40;
    localparam int unsigned MULT_RSTATUS_DEF = 4;
    localparam int unsigned DIV_RSTATUS_DEF  = 5;
    localparam int unsigned REG_RSTATUS      = 30;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } md_state_e;

    // Operation latched from execute on acceptance
    typedef struct packed {
        logic [DATA_W-1:0] op_a;
        logic [DATA_W-1:0] op_b;
        logic [REG_W-1:0]  rd;
        logic              is_mult;
    } md_req_t;

    // Zero-extended rstatus code for the operation type that faulted
    function automatic logic [DATA_W-1:0] rstatus_word(input logic        is_mult,
                                                       input int unsigned mult_rs,
                                                       input int unsigned div_rs);
        return is_mult ? DATA_W'(mult_rs) : DATA_W'(div_rs);
    endfunction

endpackage

// File: rtl/multdiv_ctrl_watchdog.sv
// BUSY-cycle watchdog for the multdiv controller.
// Ports:
//   clock, reset_n  clock and synchronous active-low reset
//   i_clr           synchronous clear (asserted while the FSM is in START)
//   i_en            count enable (asserted while the FSM is in BUSY)
//   o_first         counter is zero: this is the first BUSY cycle
//   o_expired       this is the TIMEOUT-th BUSY cycle; leave BUSY now
module multdiv_ctrl_watchdog
    import multdiv_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_first,
    output logic o_expired
);

    logic [WD_W-1:0] r_count;

    // Counts completed BUSY cycles since the last START
    always_ff @(posedge clock) begin
        if (!reset_n || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + WD_W'(1);
        end
    end

    assign o_first   = (r_count == '0);
    // Flag one cycle early so DONE lands exactly TIMEOUT cycles after BUSY entry
    assign o_expired = (r_count == WD_W'(TIMEOUT - 1));

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencing controller between execute and the multdiv unit.
// Accepts one MUL/DIV from execute, stalls the pipeline, holds operands,
// pulses the unit start for one cycle, waits for result-ready (or the
// watchdog) and presents a single writeback beat.
// Ports:
//   clock, reset_n               clock and synchronous active-low reset
//   ex_isMult/ex_isDiv           request from execute (mult wins if both)
//   ex_operandA/B, ex_rd         operands and destination from execute
//   flush                        abort any in-flight operation
//   md_result/exception/RDY      multdiv unit response
//   md_operandA/B                held operands to the unit
//   md_ctrl_MULT/DIV             one-cycle start pulses
//   stall                        freeze PC, F/D and D/X
//   wb_valid, wb_rd, wb_data     writeback beat (r30 + rstatus on exception)
module multdiv_ctrl
    import multdiv_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT      = TIMEOUT_DEF,
    parameter int unsigned MULT_RSTATUS = MULT_RSTATUS_DEF,
    parameter int unsigned DIV_RSTATUS  = DIV_RSTATUS_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              ex_isMult,
    input  logic              ex_isDiv,
    input  logic [DATA_W-1:0] ex_operandA,
    input  logic [DATA_W-1:0] ex_operandB,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              flush,
    input  logic [DATA_W-1:0] md_result,
    input  logic              md_exception,
    input  logic              md_resultRDY,
    output logic [DATA_W-1:0] md_operandA,
    output logic [DATA_W-1:0] md_operandB,
    output logic              md_ctrl_MULT,
    output logic              md_ctrl_DIV,
    output logic              stall,
    output logic              wb_valid,
    output logic [REG_W-1:0]  wb_rd,
    output logic [DATA_W-1:0] wb_data
);

    md_state_e         r_state;
    md_state_e         w_next;
    md_req_t           r_hold;
    logic [DATA_W-1:0] r_result;
    logic              r_exc;

    logic w_req;
    logic w_accept;
    logic w_capture;
    logic w_force;
    logic w_wd_first;
    logic w_wd_expired;

    assign w_req = ex_isMult | ex_isDiv;

    multdiv_ctrl_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock     (clock),
        .reset_n   (reset_n),
        .i_clr     (r_state == START),
        .i_en      (r_state == BUSY),
        .o_first   (w_wd_first),
        .o_expired (w_wd_expired)
    );

    // State register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Operand / rd / op holding register, loaded on acceptance only
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_hold <= '0;
        end else if (w_accept) begin
            r_hold <= '{op_a: ex_operandA, op_b: ex_operandB, rd: ex_rd, is_mult: ex_isMult};
        end
    end

    // Result / exception holding register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_result <= '0;
            r_exc    <= 1'b0;
        end else if (w_capture) begin
            r_result <= md_result;
            r_exc    <= md_exception;
        end else if (w_force) begin
            r_result <= '0;
            r_exc    <= 1'b1;
        end
    end

    // Next-state and output decode
    always_comb begin
        w_next       = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_force      = 1'b0;
        stall        = 1'b0;
        md_ctrl_MULT = 1'b0;
        md_ctrl_DIV  = 1'b0;
        wb_valid     = 1'b0;
        wb_rd        = '0;
        wb_data      = '0;

        case (r_state)
            IDLE: begin
                stall = w_req;
                if (w_req) begin
                    w_accept = 1'b1;
                    w_next   = START;
                end
            end
            START: begin
                stall        = 1'b1;
                md_ctrl_MULT = r_hold.is_mult & ~flush;
                md_ctrl_DIV  = ~r_hold.is_mult & ~flush;
                w_next       = BUSY;
            end
            BUSY: begin
                stall = 1'b1;
                // The unit's counter can still show a stale ready in the first BUSY cycle
                if (md_resultRDY && !w_wd_first) begin
                    w_capture = 1'b1;
                    w_next    = DONE;
                end else if (w_wd_expired) begin
                    w_force = 1'b1;
                    w_next  = DONE;
                end
            end
            DONE: begin
                wb_valid = ~flush;
                if (!flush) begin
                    wb_rd   = r_exc ? REG_W'(REG_RSTATUS) : r_hold.rd;
                    wb_data = r_exc ? rstatus_word(r_hold.is_mult, MULT_RSTATUS, DIV_RSTATUS)
                                    : r_result;
                end
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase

        // Flush overrides every transition and load
        if (flush) begin
            w_next    = IDLE;
            w_accept  = 1'b0;
            w_capture = 1'b0;
            w_force   = 1'b0;
        end
    end

    assign md_operandA = r_hold.op_a;
    assign md_operandB = r_hold.op_b;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Bench for multdiv_ctrl: a fake multdiv unit, a per-operation timeline model
// and a single process that drives, models and compares every cycle.
module tb_multdiv_ctrl;

    localparam int unsigned TMO = 40;
    localparam longint P_MAX = 64'sd2147483647;
    localparam longint P_MIN = -64'sd2147483648;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ex_isMult, ex_isDiv;
    logic [31:0] ex_operandA, ex_operandB;
    logic [4:0]  ex_rd;
    logic        flush;
    logic [31:0] md_result;
    logic        md_exception, md_resultRDY;
    logic [31:0] md_operandA, md_operandB;
    logic        md_ctrl_MULT, md_ctrl_DIV;
    logic        stall, wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    always #5 clock = ~clock;

    multdiv_ctrl #(
        .TIMEOUT      (TMO),
        .MULT_RSTATUS (4),
        .DIV_RSTATUS  (5)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .ex_isMult    (ex_isMult),
        .ex_isDiv     (ex_isDiv),
        .ex_operandA  (ex_operandA),
        .ex_operandB  (ex_operandB),
        .ex_rd        (ex_rd),
        .flush        (flush),
        .md_result    (md_result),
        .md_exception (md_exception),
        .md_resultRDY (md_resultRDY),
        .md_operandA  (md_operandA),
        .md_operandB  (md_operandB),
        .md_ctrl_MULT (md_ctrl_MULT),
        .md_ctrl_DIV  (md_ctrl_DIV),
        .stall        (stall),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: age counts cycles since the accepting IDLE cycle
    bit          m_active, m_done, m_mult, m_exc;
    int          m_age;
    logic [31:0] m_a, m_b, m_res;
    logic [4:0]  m_rd;

    // Fake multdiv unit
    bit          u_pend, u_pmult, u_stale, u_never, u_rand, u_exc;
    int          u_cnt, u_lat;
    logic [31:0] u_pa, u_pb, u_res;

    // Observation log
    int          n_wb, n_mul, n_div, n_stall, wb_cyc, pulse_cyc, stall_last;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    int          t0, s_wb, s_mul, s_div, s_stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    task automatic model_update();
        if (!reset_n) begin
            m_active = 0; m_done = 0; m_mult = 0; m_exc = 0; m_age = 0;
            m_a = '0; m_b = '0; m_res = '0; m_rd = '0;
        end else if (flush) begin
            m_active = 0; m_done = 0;
        end else if (!m_active) begin
            if (ex_isMult || ex_isDiv) begin
                m_active = 1; m_done = 0; m_age = 1;
                m_a = ex_operandA; m_b = ex_operandB; m_rd = ex_rd; m_mult = ex_isMult;
            end
        end else if (m_done) begin
            m_active = 0; m_done = 0;
        end else begin
            if (m_age >= 3 && md_resultRDY) begin
                m_done = 1; m_res = md_result; m_exc = md_exception;
            end else if (m_age == int'(TMO) + 1) begin
                m_done = 1; m_exc = 1;
            end
            m_age++;
        end
    endtask

    task automatic unit_update();
        longint p;
        if (u_pend) begin
            u_cnt = 1;
            if (u_rand) u_lat = int'($urandom_range(1, 45));
            if (u_pmult) begin
                p     = longint'($signed(u_pa)) * longint'($signed(u_pb));
                u_res = p[31:0];
                u_exc = (p > P_MAX) || (p < P_MIN);
            end else if (u_pb == 32'd0 || (u_pa == 32'h8000_0000 && u_pb == 32'hFFFF_FFFF)) begin
                u_res = '0;
                u_exc = 1;
            end else begin
                u_res = 32'($signed(u_pa) / $signed(u_pb));
                u_exc = 0;
            end
        end else if (u_cnt > 0) begin
            u_cnt++;
        end
    endtask

    task automatic unit_drive();
        bit real_rdy;
        real_rdy     = !u_never && u_cnt > 0 && u_cnt == u_lat;
        md_resultRDY = real_rdy
                     || (u_stale && (md_ctrl_MULT || md_ctrl_DIV || u_cnt == 1))
                     || (u_rand && $urandom_range(0, 7) == 0);
        if (real_rdy) begin
            md_result    = u_res;
            md_exception = u_exc;
        end else begin
            md_result    = $urandom;
            md_exception = 1'($urandom_range(0, 1));
        end
    endtask

    // One clock: compare at negedge, advance model/unit at posedge, drive unit at +1
    task automatic step();
        logic       e_stall, e_m, e_d, e_wb;
        logic [4:0] e_rd;
        logic [31:0] e_data;
        @(negedge clock);
        e_stall = 0; e_m = 0; e_d = 0; e_wb = 0; e_rd = '0; e_data = '0;
        if (!m_active) begin
            e_stall = ex_isMult | ex_isDiv;
        end else if (m_done) begin
            e_wb = !flush;
            if (e_wb) begin
                e_rd   = m_exc ? 5'd30 : m_rd;
                e_data = m_exc ? (m_mult ? 32'd4 : 32'd5) : m_res;
            end
        end else begin
            e_stall = 1;
            if (m_age == 1 && !flush) begin
                e_m = m_mult;
                e_d = !m_mult;
            end
        end
        chk("stall",        32'(stall),        32'(e_stall));
        chk("md_ctrl_MULT", 32'(md_ctrl_MULT), 32'(e_m));
        chk("md_ctrl_DIV",  32'(md_ctrl_DIV),  32'(e_d));
        chk("wb_valid",     32'(wb_valid),     32'(e_wb));
        chk("wb_rd",        32'(wb_rd),        32'(e_rd));
        chk("wb_data",      wb_data,           e_data);
        chk("md_operandA",  md_operandA,       m_a);
        chk("md_operandB",  md_operandB,       m_b);
        if (wb_valid)     begin n_wb++;  wb_cyc = cyc; wb_rd_o = wb_rd; wb_data_o = wb_data; end
        if (md_ctrl_MULT) begin n_mul++; pulse_cyc = cyc; end
        if (md_ctrl_DIV)  begin n_div++; pulse_cyc = cyc; end
        if (stall)        begin n_stall++; stall_last = cyc; end
        u_pend  = md_ctrl_MULT | md_ctrl_DIV;
        u_pmult = md_ctrl_MULT;
        u_pa    = md_operandA;
        u_pb    = md_operandB;
        @(posedge clock);
        model_update();
        unit_update();
        cyc++;
        #1;
        unit_drive();
    endtask

    // Issue one request at relative cycle 0 and run ncyc cycles
    task automatic run_op(input bit mul, input bit dv, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int ncyc, input int flush_at, input int rst_at);
        t0 = cyc; s_wb = n_wb; s_mul = n_mul; s_div = n_div; s_stall = n_stall;
        for (int k = 0; k < ncyc; k++) begin
            ex_isMult   = (k == 0) ? mul : 1'b0;
            ex_isDiv    = (k == 0) ? dv  : 1'b0;
            ex_operandA = a;
            ex_operandB = b;
            ex_rd       = rd;
            flush       = (k == flush_at);
            reset_n     = !(k == rst_at);
            step();
        end
        ex_isMult = 0; ex_isDiv = 0; flush = 0; reset_n = 1;
    endtask

    initial begin
        reset_n = 0; ex_isMult = 0; ex_isDiv = 0; ex_operandA = '0; ex_operandB = '0;
        ex_rd = '0; flush = 0; md_result = '0; md_exception = 0; md_resultRDY = 0;
        m_active = 0; m_done = 0; m_mult = 0; m_exc = 0; m_age = 0;
        m_a = '0; m_b = '0; m_res = '0; m_rd = '0;
        u_pend = 0; u_pmult = 0; u_stale = 0; u_never = 0; u_rand = 0; u_exc = 0;
        u_cnt = 0; u_lat = 16; u_pa = '0; u_pb = '0; u_res = '0;
        n_wb = 0; n_mul = 0; n_div = 0; n_stall = 0; wb_cyc = -1; pulse_cyc = -1; stall_last = -1;
        wb_rd_o = '0; wb_data_o = '0;

        @(posedge clock);
        #1;
        step();
        step();
        chk("reset_stall",   32'(stall),    32'd0);
        chk("reset_wb",      32'(wb_valid), 32'd0);
        chk("reset_opA",     md_operandA,   32'd0);
        chk("reset_wb_data", wb_data,       32'd0);
        reset_n = 1;
        step();

        // MUL 7*6 -> r3
        run_op(1, 0, 32'd7, 32'd6, 5'd3, 25, -1, -1);
        chk("mul_pulses",     32'(n_mul - s_mul),    32'd1);
        chk("mul_pulse_cyc",  32'(pulse_cyc - t0),   32'd1);
        chk("mul_no_div",     32'(n_div - s_div),    32'd0);
        chk("mul_stall_cnt",  32'(n_stall - s_stall), 32'd18);
        chk("mul_stall_last", 32'(stall_last - t0),  32'd17);
        chk("mul_wb_cyc",     32'(wb_cyc - t0),      32'd18);
        chk("mul_wb_rd",      32'(wb_rd_o),          32'd3);
        chk("mul_wb_data",    wb_data_o,             32'd42);
        chk("mul_opA_held",   md_operandA,           32'd7);
        chk("mul_opB_held",   md_operandB,           32'd6);

        // MUL overflow -> r30 = 4
        run_op(1, 0, 32'h7FFF_FFFF, 32'd2, 5'd9, 25, -1, -1);
        chk("ovf_wb_cyc",  32'(wb_cyc - t0), 32'd18);
        chk("ovf_wb_rd",   32'(wb_rd_o),     32'd30);
        chk("ovf_wb_data", wb_data_o,        32'd4);

        // DIV by zero -> r30 = 5
        run_op(0, 1, 32'd5, 32'd0, 5'd4, 25, -1, -1);
        chk("div_pulses",  32'(n_div - s_div), 32'd1);
        chk("div_no_mult", 32'(n_mul - s_mul), 32'd0);
        chk("div_wb_rd",   32'(wb_rd_o),       32'd30);
        chk("div_wb_data", wb_data_o,          32'd5);

        // Stale ready at START and first BUSY must be ignored
        u_stale = 1;
        run_op(1, 0, 32'd7, 32'd6, 5'd3, 25, -1, -1);
        u_stale = 0;
        chk("stale_wb_cnt",  32'(n_wb - s_wb), 32'd1);
        chk("stale_wb_cyc",  32'(wb_cyc - t0), 32'd18);
        chk("stale_wb_data", wb_data_o,        32'd42);

        // Flush mid-BUSY
        run_op(1, 0, 32'd11, 32'd3, 5'd8, 30, 8, -1);
        chk("flush_no_wb",      32'(n_wb - s_wb),         32'd0);
        chk("flush_stall_last", 32'(stall_last - t0),     32'd8);

        // Flush coincident with request
        run_op(1, 0, 32'd2, 32'd2, 5'd1, 12, 0, -1);
        chk("flreq_no_pulse", 32'(n_mul - s_mul + n_div - s_div), 32'd0);
        chk("flreq_no_wb",    32'(n_wb - s_wb),                  32'd0);

        // Reset mid-operation at cycle 10, outputs checked at cycle 11
        run_op(1, 0, 32'd9, 32'd9, 5'd7, 11, -1, 10);
        chk("rst11_stall", 32'(stall),        32'd0);
        chk("rst11_wb",    32'(wb_valid),     32'd0);
        chk("rst11_pulse", 32'(md_ctrl_MULT | md_ctrl_DIV), 32'd0);
        chk("rst11_wb_rd", 32'(wb_rd),        32'd0);
        chk("rst11_data",  wb_data,           32'd0);
        chk("rst11_opA",   md_operandA,       32'd0);
        chk("rst11_opB",   md_operandB,       32'd0);
        repeat (25) step();
        chk("rst_no_wb", 32'(n_wb - s_wb), 32'd0);

        // Watchdog timeout
        u_never = 1;
        run_op(1, 0, 32'd3, 32'd4, 5'd12, 50, -1, -1);
        u_never = 0;
        chk("tmo_wb_cyc",  32'(wb_cyc - t0), 32'd42);
        chk("tmo_wb_rd",   32'(wb_rd_o),     32'd30);
        chk("tmo_wb_data", wb_data_o,        32'd4);

        // Randomized traffic with noise on ready, flushes and resets
        u_rand = 1;
        for (int i = 0; i < 3000; i++) begin
            ex_isMult   = ($urandom_range(0, 2) == 0);
            ex_isDiv    = ($urandom_range(0, 3) == 0);
            ex_operandA = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 100)) : $urandom;
            ex_operandB = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            ex_rd       = 5'($urandom);
            flush       = ($urandom_range(0, 49) == 0);
            reset_n     = !($urandom_range(0, 399) == 0);
            step();
        end
        u_rand = 0; ex_isMult = 0; ex_isDiv = 0; flush = 0; reset_n = 1;
        repeat (50) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
